// File: rtl/gray_arbiter_if.sv
// Bundles the requester handshake and Gray-counter control/status seen by gray_arbiter.
// The slave modport is the arbiter's view. The master modport is the view of the requesters and counter.
interface gray_arbiter_if #(
    parameter int STEP_W = 4,
    parameter int WRAP_W = 4
);
    logic [1:0]        i_req;
    logic [1:0]        i_clr;
    logic [STEP_W-1:0] i_steps0;
    logic [STEP_W-1:0] i_steps1;
    logic [1:0]        o_gnt;
    logic [1:0]        o_done;
    logic [2:0]        o_result;
    logic [WRAP_W-1:0] o_wraps;
    logic              o_cnt_en;
    logic              o_cnt_reset;
    logic [2:0]        i_cnt_value;
    logic              i_cnt_overflow;
    logic              o_err;

    modport slave (
        input  i_req, i_clr, i_steps0, i_steps1, i_cnt_value, i_cnt_overflow,
        output o_gnt, o_done, o_result, o_wraps, o_cnt_en, o_cnt_reset, o_err
    );

    modport master (
        output i_req, i_clr, i_steps0, i_steps1, i_cnt_value, i_cnt_overflow,
        input  o_gnt, o_done, o_result, o_wraps, o_cnt_en, o_cnt_reset, o_err
    );
endinterface

// File: rtl/gray_arbiter.sv
// Round-robin sharing of one 3-bit Gray step counter between two requesters: step-N or clear, then Done + result.
// Optional GRAY_CHECK_EN adds a shadow Gray model that raises a sticky Err on counter misbehaviour.
module gray_arbiter #(
    parameter int STEP_W = 4,
    parameter int WRAP_W = 4
) (
    input  logic           i_clk,
    input  logic           i_reset,
    gray_arbiter_if.slave  bus
);
    localparam logic [2:0] ST_INIT  = 3'd0;
    localparam logic [2:0] ST_IDLE  = 3'd1;
    localparam logic [2:0] ST_STEP  = 3'd2;
    localparam logic [2:0] ST_CLEAR = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;
    localparam logic [2:0] ST_RESP  = 3'd5;

    logic [2:0]        r_state;
    logic              r_rr;
    logic              r_win;
    logic [1:0]        r_gnt;
    logic [STEP_W-1:0] r_remain;
    logic [WRAP_W-1:0] r_wrap;
    logic [2:0]        r_result;
    logic [WRAP_W-1:0] r_wraps;

    logic              w_win;
    logic [STEP_W-1:0] w_steps;

    always_comb begin
        w_win = 1'b0;
        if (bus.i_req == 2'b11) begin
            w_win = r_rr;
        end else begin
            w_win = bus.i_req[1];
        end
        w_steps = w_win ? bus.i_steps1 : bus.i_steps0;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= ST_INIT;
            r_rr     <= 1'b0;
            r_win    <= 1'b0;
            r_gnt    <= 2'b00;
            r_remain <= '0;
            r_wrap   <= '0;
            r_result <= 3'b000;
            r_wraps  <= '0;
        end else begin
            case (r_state)
                ST_INIT: r_state <= ST_IDLE;
                ST_IDLE: begin
                    if (bus.i_req != 2'b00) begin
                        r_win    <= w_win;
                        r_gnt    <= w_win ? 2'b10 : 2'b01;
                        r_remain <= w_steps;
                        r_wrap   <= '0;
                        if (bus.i_clr[w_win]) begin
                            r_state <= ST_CLEAR;
                        end else if (w_steps == '0) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_state <= ST_STEP;
                        end
                    end
                end
                ST_STEP: begin
                    // Value 100 is the last code before the counter rolls back to 000.
                    if (bus.i_cnt_value == 3'b100 && !(&r_wrap)) begin
                        r_wrap <= r_wrap + 1'b1;
                    end
                    r_remain <= r_remain - 1'b1;
                    if (r_remain == STEP_W'(1)) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_CLEAR: r_state <= ST_DONE;
                ST_DONE: begin
                    r_result <= bus.i_cnt_value;
                    r_wraps  <= r_wrap;
                    r_state  <= ST_RESP;
                end
                ST_RESP: begin
                    r_gnt   <= 2'b00;
                    r_rr    <= ~r_win;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_INIT;
            endcase
        end
    end

    assign bus.o_gnt       = r_gnt;
    assign bus.o_done      = (r_state == ST_RESP) ? r_gnt : 2'b00;
    assign bus.o_result    = r_result;
    assign bus.o_wraps     = r_wraps;
    assign bus.o_cnt_en    = (r_state == ST_INIT) || (r_state == ST_STEP) || (r_state == ST_CLEAR);
    assign bus.o_cnt_reset = (r_state == ST_INIT) || (r_state == ST_CLEAR);

`ifdef GRAY_CHECK_EN
    logic [2:0] r_exp;
    logic       r_wrapped;
    logic       r_err;

    function automatic logic [2:0] gray_next(input logic [2:0] g);
        logic [2:0] b;
        b[2] = g[2];
        b[1] = b[2] ^ g[1];
        b[0] = b[1] ^ g[0];
        b    = b + 3'd1;
        return b ^ (b >> 1);
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_exp     <= 3'b000;
            r_wrapped <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_exp     <= 3'b000;
                    r_wrapped <= 1'b0;
                end
                ST_CLEAR: r_exp <= 3'b000;
                ST_STEP: begin
                    r_exp <= gray_next(r_exp);
                    if (bus.i_cnt_value == 3'b100) begin
                        r_wrapped <= 1'b1;
                    end
                end
                ST_IDLE, ST_DONE, ST_RESP: begin
                    // Only checked while the counter is idle, so its value must match the model exactly.
                    if (bus.i_cnt_value != r_exp || (r_wrapped && !bus.i_cnt_overflow)) begin
                        r_err <= 1'b1;
                    end
                end
                default: r_exp <= r_exp;
            endcase
        end
    end

    assign bus.o_err = r_err;
`else
    assign bus.o_err = 1'b0;
`endif
endmodule
